// File: rtl/rx_os_pkg.sv
// rx_os_pkg
//   Shared definitions for the ordered-set consensus block:
//   completion result codes, FSM state encoding, byte offsets of the
//   fields inside one decoded ordered set, and the training-set IDs.
//   No ports; imported by rx_os_lane_cnt and rx_os_consensus.
package rx_os_pkg;

  typedef enum logic [1:0] {
    RES_MATCH   = 2'd0,
    RES_TIMEOUT = 2'd1,
    RES_EIDLE   = 2'd2,
    RES_NOLANE  = 2'd3
  } result_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte positions of fields within one lane's ordered set.
  localparam int OS_BYTE_ID   = 0;
  localparam int OS_BYTE_LINK = 1;
  localparam int OS_BYTE_RATE = 4;
  // Upconfigure capability bit inside the rate-ID byte.
  localparam int UPCFG_BIT    = 6;

  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

endpackage

// File: rtl/rx_os_lane_cnt.sv
// rx_os_lane_cnt
//   One lane of the consensus logic: compares the lane's identifier and
//   link-number bytes against the expected values and keeps a saturating
//   count of consecutive matching ordered sets.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   i_clr             force the counter to zero (idle or restart)
//   i_mask            lane takes part; an unmasked lane stays at zero
//   i_step            a valid ordered set is present this cycle
//   i_id_byte         byte 0 of this lane's ordered set
//   i_link_byte       byte 1 of this lane's ordered set
//   i_expect_id       required identifier
//   i_link_chk_en     also require the link number to match
//   i_expect_link     required link number
//   o_cnt_next        next-state counter value (consensus is judged on it)
module rx_os_lane_cnt
  import rx_os_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_mask,
  input  logic             i_step,
  input  logic [7:0]       i_id_byte,
  input  logic [7:0]       i_link_byte,
  input  logic [7:0]       i_expect_id,
  input  logic             i_link_chk_en,
  input  logic [7:0]       i_expect_link,
  output logic [CNT_W-1:0] o_cnt_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_match;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_match = (i_id_byte == i_expect_id) &&
                   (!i_link_chk_en || (i_link_byte == i_expect_link));

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clr || !i_mask) begin
      w_cnt_next = '0;
    end else if (i_step) begin
      if (!w_match) begin
        w_cnt_next = '0;
      end else if (r_cnt != CNT_MAX) begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_cnt_next = w_cnt_next;

endmodule

// File: rtl/rx_os_consensus.sv
// rx_os_consensus
//   Watches decoded ordered sets on up to 32 lanes and decides when the
//   masked lanes agree: every masked lane (or any one, in any_mode) has
//   seen req_count consecutive matching sets. Ends with MATCH, TIMEOUT,
//   EIDLE (electrical-idle abort) or NOLANE (empty mask), pulsing done.
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   os_bus, os_valid                per-lane ordered sets and their strobe
//   lane_mask                       lanes taking part
//   start                           begin / restart an evaluation
//   any_mode, req_count             consensus rule and threshold (0 => 1)
//   expect_id                       required identifier (byte 0)
//   link_chk_en, expect_link        optional link-number check (byte 1)
//   eidle_abort_en, rx_eidle        electrical-idle abort
//   timeout_ticks                   cycles allowed in RUN
//   busy, done, result              status; result held until next completion
//   qual_lanes                      lanes at or above threshold at completion
//   link_num, rate_id, upcfg        fields of the lowest qualifying lane
module rx_os_consensus
  import rx_os_pkg::*;
#(
  parameter int LANES = 16,
  parameter int OS_W  = 128,
  parameter int CNT_W = 5,
  parameter int TMR_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES*OS_W-1:0] os_bus,
  input  logic                  os_valid,
  input  logic [LANES-1:0]      lane_mask,
  input  logic                  start,
  input  logic                  any_mode,
  input  logic [CNT_W-1:0]      req_count,
  input  logic [7:0]            expect_id,
  input  logic                  link_chk_en,
  input  logic [7:0]            expect_link,
  input  logic                  eidle_abort_en,
  input  logic                  rx_eidle,
  input  logic [TMR_W-1:0]      timeout_ticks,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            result,
  output logic [LANES-1:0]      qual_lanes,
  output logic [7:0]            link_num,
  output logic [7:0]            rate_id,
  output logic                  upcfg
);

  state_e           r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_busy;
  logic             r_done;
  result_e          r_result;
  logic [LANES-1:0] r_qual;
  logic [7:0]       r_link;
  logic [7:0]       r_rate;
  logic             r_upcfg;

  logic             w_clr;
  logic [CNT_W-1:0] w_req_eff;
  logic [CNT_W-1:0] w_cnt_next [LANES];
  logic [LANES-1:0] w_qual;
  logic [LANES-1:0] w_seen;
  logic [LANES-1:0] w_first;
  logic [7:0]       w_lane_link [LANES];
  logic [7:0]       w_lane_rate [LANES];
  logic [LANES-1:0] w_unused_os;
  logic [7:0]       w_sel_link;
  logic [7:0]       w_sel_rate;
  logic             w_all_ok;
  logic             w_any_ok;
  logic             w_consensus;

  // Counters are held at zero outside RUN, and a start wipes them.
  assign w_clr     = start || (r_state != ST_RUN);
  assign w_req_eff = (req_count == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : req_count;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    rx_os_lane_cnt #(
      .CNT_W(CNT_W)
    ) u_lane_cnt (
      .clk          (clk),
      .reset        (reset),
      .i_clr        (w_clr),
      .i_mask       (lane_mask[gi]),
      .i_step       (os_valid),
      .i_id_byte    (os_bus[gi*OS_W + OS_BYTE_ID*8 +: 8]),
      .i_link_byte  (os_bus[gi*OS_W + OS_BYTE_LINK*8 +: 8]),
      .i_expect_id  (expect_id),
      .i_link_chk_en(link_chk_en),
      .i_expect_link(expect_link),
      .o_cnt_next   (w_cnt_next[gi])
    );

    assign w_lane_link[gi] = os_bus[gi*OS_W + OS_BYTE_LINK*8 +: 8];
    assign w_lane_rate[gi] = os_bus[gi*OS_W + OS_BYTE_RATE*8 +: 8];
    // Bytes 2-3 and everything past byte 4 carry nothing this block needs.
    assign w_unused_os[gi] = ^{os_bus[gi*OS_W + 16 +: 16],
                               os_bus[gi*OS_W + 40 +: OS_W-40]};

    assign w_qual[gi] = lane_mask[gi] && (w_cnt_next[gi] >= w_req_eff);

    // Priority encoder: a lane is "first" if it qualifies and no lower
    // lane does.
    if (gi == 0) begin : g_seen0
      assign w_seen[gi] = 1'b0;
    end else begin : g_seenn
      assign w_seen[gi] = w_seen[gi-1] | w_qual[gi-1];
    end
    assign w_first[gi] = w_qual[gi] & ~w_seen[gi];
  end

  // w_first is one-hot or zero, so an OR-mux picks the winning lane.
  always_comb begin
    w_sel_link = '0;
    w_sel_rate = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_first[i]) begin
        w_sel_link = w_sel_link | w_lane_link[i];
        w_sel_rate = w_sel_rate | w_lane_rate[i];
      end
    end
  end

  assign w_all_ok    = (lane_mask != '0) && (w_qual == lane_mask);
  assign w_any_ok    = |w_qual;
  assign w_consensus = any_mode ? w_any_ok : w_all_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= RES_NOLANE;
      r_qual   <= '0;
      r_link   <= '0;
      r_rate   <= '0;
      r_upcfg  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        // Start wins over any evaluation in flight; the old result stays.
        if (lane_mask == '0) begin
          r_state  <= ST_DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_result <= RES_NOLANE;
          r_qual   <= '0;
        end else begin
          r_state <= ST_RUN;
          r_busy  <= 1'b1;
          r_timer <= timeout_ticks;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_busy <= 1'b0;
          end
          ST_RUN: begin
            if (eidle_abort_en && rx_eidle) begin
              r_state  <= ST_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= RES_EIDLE;
              r_qual   <= w_qual;
            end else if (w_consensus) begin
              r_state  <= ST_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= RES_MATCH;
              r_qual   <= w_qual;
              r_link   <= w_sel_link;
              r_rate   <= w_sel_rate;
              r_upcfg  <= w_sel_rate[UPCFG_BIT];
            end else if (r_timer == '0) begin
              r_state  <= ST_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= RES_TIMEOUT;
              r_qual   <= w_qual;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign qual_lanes = r_qual;
  assign link_num   = r_link;
  assign rate_id    = r_rate;
  assign upcfg      = r_upcfg;

endmodule

// File: tb/tb_rx_os_consensus.sv
// tb_rx_os_consensus
//   Directed bench for rx_os_consensus with 4 lanes; expected values are
//   worked out by hand for each scenario.
module tb_rx_os_consensus;

  localparam int LANES = 4;
  localparam int OS_W  = 128;
  localparam int CNT_W = 5;
  localparam int TMR_W = 24;

  localparam logic [1:0] R_MATCH   = 2'd0;
  localparam logic [1:0] R_TIMEOUT = 2'd1;
  localparam logic [1:0] R_EIDLE   = 2'd2;
  localparam logic [1:0] R_NOLANE  = 2'd3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [LANES*OS_W-1:0] os_bus;
  logic                  os_valid;
  logic [LANES-1:0]      lane_mask;
  logic                  start;
  logic                  any_mode;
  logic [CNT_W-1:0]      req_count;
  logic [7:0]            expect_id;
  logic                  link_chk_en;
  logic [7:0]            expect_link;
  logic                  eidle_abort_en;
  logic                  rx_eidle;
  logic [TMR_W-1:0]      timeout_ticks;
  logic                  busy;
  logic                  done;
  logic [1:0]            result;
  logic [LANES-1:0]      qual_lanes;
  logic [7:0]            link_num;
  logic [7:0]            rate_id;
  logic                  upcfg;

  int n_checks = 0;
  int n_fail   = 0;

  rx_os_consensus #(
    .LANES(LANES), .OS_W(OS_W), .CNT_W(CNT_W), .TMR_W(TMR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .os_bus        (os_bus),
    .os_valid      (os_valid),
    .lane_mask     (lane_mask),
    .start         (start),
    .any_mode      (any_mode),
    .req_count     (req_count),
    .expect_id     (expect_id),
    .link_chk_en   (link_chk_en),
    .expect_link   (expect_link),
    .eidle_abort_en(eidle_abort_en),
    .rx_eidle      (rx_eidle),
    .timeout_ticks (timeout_ticks),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .qual_lanes    (qual_lanes),
    .link_num      (link_num),
    .rate_id       (rate_id),
    .upcfg         (upcfg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [7:0] id,
                          input logic [7:0] link, input logic [7:0] rate);
    logic [OS_W-1:0] os;
    os = '0;
    os[7:0]   = id;
    os[15:8]  = link;
    os[39:32] = rate;
    os[OS_W-1:OS_W-8] = 8'hA5;  // filler in an ignored byte
    os_bus[lane*OS_W +: OS_W] = os;
  endtask

  task automatic all_lanes(input logic [7:0] id, input logic [7:0] link,
                           input logic [7:0] rate);
    for (int i = 0; i < LANES; i++) set_lane(i, id, link, rate);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles until done is seen; -1 when the budget runs out.
  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      tick();
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  int cyc;
  int seen_done;

  initial begin
    reset = 1'b0; os_bus = '0; os_valid = 1'b0; lane_mask = '0; start = 1'b0;
    any_mode = 1'b0; req_count = 5'd8; expect_id = 8'h4A; link_chk_en = 1'b0;
    expect_link = 8'h00; eidle_abort_en = 1'b0; rx_eidle = 1'b0;
    timeout_ticks = 24'd1000;

    // Reset values
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'(R_NOLANE));
    chk("rst_qual", 32'(qual_lanes), 32'd0);
    chk("rst_link", 32'(link_num), 32'd0);
    chk("rst_rate", 32'(rate_id), 32'd0);
    chk("rst_upcfg", 32'(upcfg), 32'd0);
    reset = 1'b1;
    tick();

    // All four lanes see TS1 for 8 valid cycles -> done right after the 8th
    all_lanes(8'h4A, 8'h00, 8'h00);
    lane_mask = 4'hF; any_mode = 1'b0; req_count = 5'd8;
    do_start();
    chk("t1_busy", 32'(busy), 32'd1);
    os_valid = 1'b1;
    wait_done(40, cyc);
    chk("t1_lat", 32'(cyc), 32'd8);
    chk("t1_result", 32'(result), 32'(R_MATCH));
    chk("t1_qual", 32'(qual_lanes), 32'hF);
    chk("t1_busy_off", 32'(busy), 32'd0);
    os_valid = 1'b0;
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // Lane 2 breaks on the 5th set and must rebuild 8 matches
    do_start();
    os_valid = 1'b1;
    repeat (4) tick();
    set_lane(2, 8'h00, 8'h00, 8'h00);
    tick();
    chk("t2_no_early", 32'(done), 32'd0);
    set_lane(2, 8'h4A, 8'h00, 8'h00);
    wait_done(40, cyc);
    chk("t2_lat", 32'(cyc), 32'd8);
    chk("t2_result", 32'(result), 32'(R_MATCH));
    os_valid = 1'b0;
    tick();

    // any_mode: lowest qualifying lane (1) supplies the fields; lane 0 unmasked
    set_lane(0, 8'h4A, 8'h07, 8'h00);
    set_lane(1, 8'h4A, 8'h03, 8'h4E);
    set_lane(2, 8'h4A, 8'h05, 8'h0A);
    set_lane(3, 8'h00, 8'h00, 8'h00);
    lane_mask = 4'b0110; any_mode = 1'b1; req_count = 5'd2;
    do_start();
    os_valid = 1'b1;
    wait_done(20, cyc);
    chk("t3_lat", 32'(cyc), 32'd2);
    chk("t3_result", 32'(result), 32'(R_MATCH));
    chk("t3_link", 32'(link_num), 32'h03);
    chk("t3_rate", 32'(rate_id), 32'h4E);
    chk("t3_upcfg", 32'(upcfg), 32'd1);
    chk("t3_qual", 32'(qual_lanes), 32'h6);
    os_valid = 1'b0;
    tick();

    // Only lane 2 matches, req_count=0 acts as 1; link check enabled
    set_lane(1, 8'h45, 8'h03, 8'h4E);
    link_chk_en = 1'b1; expect_link = 8'h05; req_count = 5'd0;
    do_start();
    os_valid = 1'b1;
    wait_done(20, cyc);
    chk("t3b_lat", 32'(cyc), 32'd1);
    chk("t3b_link", 32'(link_num), 32'h05);
    chk("t3b_rate", 32'(rate_id), 32'h0A);
    chk("t3b_upcfg", 32'(upcfg), 32'd0);
    chk("t3b_qual", 32'(qual_lanes), 32'h4);
    os_valid = 1'b0; link_chk_en = 1'b0;
    tick();

    // Timeout: 20 ticks, no traffic -> done after 21 RUN cycles
    lane_mask = 4'hF; any_mode = 1'b0; req_count = 5'd8; timeout_ticks = 24'd20;
    do_start();
    wait_done(60, cyc);
    chk("t4_lat", 32'(cyc), 32'd21);
    chk("t4_result", 32'(result), 32'(R_TIMEOUT));
    chk("t4_link_kept", 32'(link_num), 32'h05);
    tick();
    timeout_ticks = 24'd0;
    do_start();
    wait_done(10, cyc);
    chk("t4b_lat", 32'(cyc), 32'd1);
    chk("t4b_result", 32'(result), 32'(R_TIMEOUT));
    tick();

    // Electrical idle in the cycle the 8th match lands -> EIDLE wins
    all_lanes(8'h4A, 8'h11, 8'h22);
    timeout_ticks = 24'd1000; eidle_abort_en = 1'b1;
    do_start();
    os_valid = 1'b1;
    repeat (7) tick();
    rx_eidle = 1'b1;
    wait_done(5, cyc);
    chk("t5_lat", 32'(cyc), 32'd1);
    chk("t5_result", 32'(result), 32'(R_EIDLE));
    chk("t5_qual", 32'(qual_lanes), 32'hF);
    chk("t5_rate_kept", 32'(rate_id), 32'h0A);
    os_valid = 1'b0; rx_eidle = 1'b0; eidle_abort_en = 1'b0;
    tick();

    // Restart mid-RUN: old result kept, 8 fresh matches needed
    do_start();
    os_valid = 1'b1;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_result_kept", 32'(result), 32'(R_EIDLE));
    wait_done(40, cyc);
    chk("t6_lat", 32'(cyc), 32'd8);
    chk("t6_link", 32'(link_num), 32'h11);
    os_valid = 1'b0;
    tick();

    // Empty mask -> NOLANE next cycle
    lane_mask = 4'h0;
    do_start();
    chk("t7_done", 32'(done), 32'd1);
    chk("t7_result", 32'(result), 32'(R_NOLANE));
    tick();
    chk("t7_done_off", 32'(done), 32'd0);

    // Reset mid-RUN: no done, outputs back to reset values
    lane_mask = 4'hF;
    do_start();
    os_valid = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) seen_done++;
    end
    chk("t8_no_done", 32'(seen_done), 32'd0);
    chk("t8_busy", 32'(busy), 32'd0);
    chk("t8_result", 32'(result), 32'(R_NOLANE));
    chk("t8_qual", 32'(qual_lanes), 32'd0);
    chk("t8_link", 32'(link_num), 32'd0);
    chk("t8_rate", 32'(rate_id), 32'd0);
    chk("t8_upcfg", 32'(upcfg), 32'd0);
    os_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
